inv_sum: RTL
============

Name: inv_sum

Overview:
Inverse of the triangular-sum block. It takes a 9-bit value V from the switches and, on the slow clock, subtracts 1, 2, 3, … until the next term no longer fits. It reports the largest k with 1+2+…+k ≤ V, the remainder V − k(k+1)/2, and an exact flag. Results drive the board's active-low 7-segment displays as decimal: k on HEX1:HEX0, remainder on HEX3:HEX2. The block sits beside the sum block, shares the same clock divider output, and is the decoder direction of that computation.

Parameters:
VW, 9, width of input value V (max 511)
KW, 5, width of k and remainder (max 31)

Ports:
clklento  input  1  slow clock from clock_divider (FREQ=2); all state on rising edge
rst  input  1  reset, asynchronous, active-high
V  input  VW  value to decompose; sampled only on start acceptance
start  input  1  level request; accepted in IDLE when high
busy  output  1  high in SUB
done  output  1  high in DONE
k_out  output  KW  registered result k
rem_out  output  KW  registered remainder
exact  output  1  registered, 1 when rem_out == 0
HEX0  output  [0:6]  ones digit of k_out, active-low, segment order a..g
HEX1  output  [0:6]  tens digit of k_out
HEX2  output  [0:6]  ones digit of rem_out
HEX3  output  [0:6]  tens digit of rem_out

Behaviour:
- Reset (async, any state): state=IDLE; acc=0; k=0; k_out=0; rem_out=0; exact=1; busy=0; done=0. HEX0..HEX3 all show "0" (0000001).
- Internal registers: acc[VW-1:0], k[KW-1:0]. Next term is t = k+1, computed VW bits wide with zero-extension. No truncation is allowed.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - start=0 → stay in IDLE.
  - start=1 → acc<=V, k<=0, go to SUB.
- SUB, one step per edge:
  - If acc ≥ t: acc<=acc−t, k<=k+1, stay in SUB.
  - Else: k_out<=k, rem_out<=acc[KW-1:0], exact<=(acc==0), go to DONE.
- DONE:
  - Hold all outputs.
  - start=0 → IDLE.
  - start=1 → stay in DONE. Start must be released and reasserted to run again; no auto-retrigger.
- Latency: for result k, done rises after the (k+2)-th rising edge counted from the acceptance edge (the acceptance edge is edge 1). V=0 gives done after edge 2; V=496 after edge 33.
- Range:
  - V ≤ 511 guarantees k ≤ 31, since 528 > 511.
  - At termination rem < k+1 ≤ 32, so KW bits suffice.
  - k never wraps.
- Ignored inputs:
  - V changes during SUB/DONE have no effect.
  - start toggles during SUB have no effect.
- k_out, rem_out and exact keep their previous values through IDLE and SUB. They update only on the SUB→DONE edge.
- HEX outputs are combinational from k_out/rem_out only: tens = value/10, ones = value%10, digits 0-3 for tens. No glitch requirement beyond registered sources.
- Reset mid-SUB aborts immediately. Outputs return to reset values and no done pulse occurs.
- busy and done are decoded from the state register. They are never high together.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=0, SUB=1, DONE=2 (2-bit);
  - the 7-seg patterns for digits 0-9, active-low [0:6], shared with the sum block.
- One natural sub-module: seg7_dec (4-bit digit → [0:6] active-low pattern), instantiated 4×. The sum block reuses it.
- The binary-to-two-digit split stays in inv_sum.

Test Plan:
- V=0, start pulse high 1 edge, then low → done after edge 2, k_out=0, rem_out=0, exact=1, HEX1:HEX0="00".
- V=10, start held high → busy edges 2-5, done after edge 6, k_out=4, rem_out=0, exact=1; holds DONE while start=1; returns to IDLE one edge after start=0.
- V=14 → k_out=4, rem_out=4, exact=0, HEX3:HEX2="04". V=496 → k_out=31, rem_out=0, done after edge 33. V=511 → k_out=31, rem_out=15, HEX1:HEX0="31", HEX3:HEX2="15".
- V=100, change V to 7 at edge 3 → result from 100: k_out=13, rem_out=9 (91+9).
- Assert rst async mid-SUB (V=200, edge 5) → immediately IDLE, busy=0, k_out=0, HEX0="0". After release, new start with V=3 → k_out=2, rem_out=0.
- Back-to-back: after DONE with V=10, start low 1 edge, then high with V=6 → k_out=3, rem_out=0. Old result is visible until the new DONE edge.

Source files
------------

// File: rtl/inv_sum_pkg.sv
// inv_sum_pkg: shared types and 7-segment patterns for the triangular sum/inverse blocks.
// Holds the 2-bit FSM state encoding and the active-low digit patterns (segment order a..g).
// Imported by inv_sum, seg7_dec and the companion sum block.
package inv_sum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Active-low pattern, bit [0] is segment a, bit [6] is segment g.
  // Non-decimal codes blank the display.
  function automatic logic [0:6] seg7_pattern(input logic [3:0] d);
    logic [0:6] p;
    case (d)
      4'd0:    p = 7'b0000001;
      4'd1:    p = 7'b1001111;
      4'd2:    p = 7'b0010010;
      4'd3:    p = 7'b0000110;
      4'd4:    p = 7'b1001100;
      4'd5:    p = 7'b0100100;
      4'd6:    p = 7'b0100000;
      4'd7:    p = 7'b0001111;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0000100;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/inv_sum_if.sv
// inv_sum_if: request/result bundle between the switch/display glue and inv_sum.
// Ports: V/start (requests), busy/done/k_out/rem_out/exact (results), HEX0..HEX3 (displays).
// master drives V/start and observes results; slave is the inv_sum side.
interface inv_sum_if #(
  parameter int VW = 9,
  parameter int KW = 5
);
  logic [VW-1:0] V;
  logic          start;
  logic          busy;
  logic          done;
  logic [KW-1:0] k_out;
  logic [KW-1:0] rem_out;
  logic          exact;
  logic [0:6]    HEX0;
  logic [0:6]    HEX1;
  logic [0:6]    HEX2;
  logic [0:6]    HEX3;

  modport master (
    output V, start,
    input  busy, done, k_out, rem_out, exact, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  V, start,
    output busy, done, k_out, rem_out, exact, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/inv_sum_seg7_dec.sv
// seg7_dec: one decimal digit to an active-low 7-segment pattern (a..g).
// Ports: digit_i (4-bit digit), seg_o ([0:6] pattern). Purely combinational.
// No handshake; output follows the input directly.
module seg7_dec
  import inv_sum_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [0:6] seg_o
);

  assign seg_o = seg7_pattern(digit_i);

endmodule

// File: rtl/inv_sum.sv
// inv_sum: finds largest k with 1+..+k <= V by repeated subtraction, plus remainder/exact flag.
// Ports: clklento/rst, bus (slave): V/start in, busy/done/k_out/rem_out/exact/HEX0..3 out.
// Latency k+2 edges from acceptance; start is a level, must drop in DONE before a rerun.
module inv_sum
  import inv_sum_pkg::*;
#(
  parameter int VW = 9,
  parameter int KW = 5
) (
  input  logic        clklento,
  input  logic        rst,
  inv_sum_if.slave    bus
);

  state_t        state_q, state_d;
  logic [VW-1:0] acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] k_out_q, k_out_d;
  logic [KW-1:0] rem_q, rem_d;
  logic          exact_q, exact_d;
  logic [VW-1:0] term;

  // Next term k+1 at full accumulator width so k=31 gives 32, not 0.
  assign term = {{(VW-KW){1'b0}}, k_q} + VW'(1);

  // State register
  always_ff @(posedge clklento or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      k_out_q <= '0;
      rem_q   <= '0;
      exact_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      k_out_q <= k_out_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    k_out_d = k_out_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.V;
          k_d     = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        if (acc_q >= term) begin
          acc_d = acc_q - term;
          k_d   = k_q + KW'(1);
        end else begin
          // Remainder is below k+1 <= 32 here, so the low KW bits hold it exactly.
          k_out_d = k_q;
          rem_d   = acc_q[KW-1:0];
          exact_d = (acc_q == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy = (state_q == ST_SUB);
    bus.done = (state_q == ST_DONE);
  end

  assign bus.k_out   = k_out_q;
  assign bus.rem_out = rem_q;
  assign bus.exact   = exact_q;

  // Split a 0..31 value into tens (0..3) and ones digits.
  function automatic logic [7:0] to_bcd(input logic [KW-1:0] v);
    logic [KW-1:0] r;
    logic [3:0]    t;
    r = v;
    t = 4'd0;
    if (r >= KW'(30)) begin
      t = 4'd3; r = r - KW'(30);
    end else if (r >= KW'(20)) begin
      t = 4'd2; r = r - KW'(20);
    end else if (r >= KW'(10)) begin
      t = 4'd1; r = r - KW'(10);
    end
    return {t, 4'(r)};
  endfunction

  logic [7:0] k_bcd, r_bcd;
  assign k_bcd = to_bcd(k_out_q);
  assign r_bcd = to_bcd(rem_q);

  seg7_dec u_hex0 (.digit_i(k_bcd[3:0]), .seg_o(bus.HEX0));
  seg7_dec u_hex1 (.digit_i(k_bcd[7:4]), .seg_o(bus.HEX1));
  seg7_dec u_hex2 (.digit_i(r_bcd[3:0]), .seg_o(bus.HEX2));
  seg7_dec u_hex3 (.digit_i(r_bcd[7:4]), .seg_o(bus.HEX3));

endmodule
